// File: rtl/li_expander.sv
// Expands li/la pseudo-instructions into LUI/AUIPC/ADDI words on a valid/ready stream.
// The whole sequence is decoded at request accept; later input changes cannot affect it.
module li_expander (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iREQ_VALID,
  output logic        oREQ_READY,
  input  logic        iMODE,
  input  logic [4:0]  iRD,
  input  logic [31:0] iVALUE,
  input  logic [7:0]  iPC,
  output logic [31:0] oIR,
  output logic        oIR_VALID,
  input  logic        iIR_READY,
  output logic        oLAST
);

  // state | meaning
  // IDLE  | ready for a request, nothing presented
  // EMIT1 | presenting first word of the sequence
  // EMIT2 | presenting trailing ADDI
  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  state_t      state, state_next;
  logic [31:0] word1, word2;
  logic        two_words;

  logic [31:0] v, v_rnd;
  logic [19:0] hi;
  logic [11:0] lo;
  logic        fits12;
  logic [31:0] w1_c, w2_c, upper_c;
  logic        two_c;
  logic        accept;

  always_comb begin
    v       = iMODE ? (iVALUE - {24'b0, iPC}) : iVALUE;
    v_rnd   = v + 32'h0000_0800;
    hi      = v_rnd[31:12];
    lo      = v[11:0];
    fits12  = (&v[31:11]) | (~|v[31:11]);
    upper_c = {hi, iRD, (iMODE ? OP_AUIPC : OP_LUI)};
    w2_c    = {lo, iRD, 3'b000, iRD, OP_IMM};
    w1_c    = upper_c;
    two_c   = 1'b0;
    if (iRD == 5'd0) begin
      w1_c = NOP;
    end else if (!iMODE && fits12) begin
      w1_c = {lo, 5'd0, 3'b000, iRD, OP_IMM};
    end else if (lo != 12'd0) begin
      two_c = 1'b1;
    end
  end

  assign accept = iREQ_VALID && oREQ_READY;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= IDLE;
      word1     <= '0;
      word2     <= '0;
      two_words <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        word1     <= w1_c;
        word2     <= w2_c;
        two_words <= two_c;
      end
    end
  end

  always_comb begin
    state_next = state;
    oREQ_READY = 1'b0;
    oIR        = '0;
    oIR_VALID  = 1'b0;
    oLAST      = 1'b0;
    case (state)
      IDLE: begin
        oREQ_READY = !iRST;
        if (accept) state_next = EMIT1;
      end
      EMIT1: begin
        oIR       = word1;
        oIR_VALID = 1'b1;
        oLAST     = !two_words;
        if (iIR_READY) state_next = two_words ? EMIT2 : IDLE;
      end
      EMIT2: begin
        oIR       = word2;
        oIR_VALID = 1'b1;
        oLAST     = 1'b1;
        if (iIR_READY) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_li_expander.sv
// Table-driven bench for li_expander with directed backpressure and reset sequences.
module tb_li_expander;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iREQ_VALID;
  logic        oREQ_READY;
  logic        iMODE;
  logic [4:0]  iRD;
  logic [31:0] iVALUE;
  logic [7:0]  iPC;
  logic [31:0] oIR;
  logic        oIR_VALID;
  logic        iIR_READY;
  logic        oLAST;

  li_expander dut (
    .iCLK(iCLK), .iRST(iRST), .iREQ_VALID(iREQ_VALID), .oREQ_READY(oREQ_READY),
    .iMODE(iMODE), .iRD(iRD), .iVALUE(iVALUE), .iPC(iPC),
    .oIR(oIR), .oIR_VALID(oIR_VALID), .iIR_READY(iIR_READY), .oLAST(oLAST)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic        mode;
    logic [4:0]  rd;
    logic [31:0] value;
    logic [7:0]  pc;
    int          nwords;
    logic [31:0] w1;
    logic [31:0] w2;
  } vec_t;

  vec_t vecs[9];
  int n_cmp = 0;
  int n_err = 0;
  int addi_hs = 0;
  logic mon_en = 1'b0;

  always @(posedge iCLK)
    if (mon_en && oIR_VALID && iIR_READY && oIR == 32'h6782_8293) addi_hs++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic request(input logic mode, input logic [4:0] rd,
                         input logic [31:0] value, input logic [7:0] pc);
    iMODE = mode; iRD = rd; iVALUE = value; iPC = pc;
    iREQ_VALID = 1'b1;
    @(negedge iCLK);
    iREQ_VALID = 1'b0;
    iVALUE = ~value; iRD = ~rd; iMODE = ~mode; iPC = ~pc;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    chk($sformatf("v%0d ready_idle", idx), {31'b0, oREQ_READY}, 32'd1);
    iIR_READY = 1'b1;
    request(v.mode, v.rd, v.value, v.pc);
    chk($sformatf("v%0d w1", idx), oIR, v.w1);
    chk($sformatf("v%0d w1_valid", idx), {31'b0, oIR_VALID}, 32'd1);
    chk($sformatf("v%0d w1_last", idx), {31'b0, oLAST}, (v.nwords == 1) ? 32'd1 : 32'd0);
    chk($sformatf("v%0d busy_ready", idx), {31'b0, oREQ_READY}, 32'd0);
    @(negedge iCLK);
    if (v.nwords == 2) begin
      chk($sformatf("v%0d w2", idx), oIR, v.w2);
      chk($sformatf("v%0d w2_valid", idx), {31'b0, oIR_VALID}, 32'd1);
      chk($sformatf("v%0d w2_last", idx), {31'b0, oLAST}, 32'd1);
      @(negedge iCLK);
    end
    chk($sformatf("v%0d end_valid", idx), {31'b0, oIR_VALID}, 32'd0);
    chk($sformatf("v%0d end_ready", idx), {31'b0, oREQ_READY}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{1'b0, 5'd5,  32'h1234_5678, 8'h00, 2, 32'h1234_52B7, 32'h6782_8293};
    vecs[1] = '{1'b0, 5'd1,  32'hFFFF_F800, 8'h00, 1, 32'h8000_0093, 32'h0};
    vecs[2] = '{1'b0, 5'd0,  32'hFFFF_F800, 8'h00, 1, 32'h0000_0013, 32'h0};
    vecs[3] = '{1'b0, 5'd2,  32'h0000_0800, 8'h00, 2, 32'h0000_1137, 32'h8001_0113};
    vecs[4] = '{1'b0, 5'd3,  32'hABCD_E000, 8'h00, 1, 32'hABCD_E1B7, 32'h0};
    vecs[5] = '{1'b1, 5'd10, 32'h0000_0100, 8'h40, 2, 32'h0000_0517, 32'h0C05_0513};
    vecs[6] = '{1'b1, 5'd1,  32'h0000_1010, 8'h10, 1, 32'h0000_1097, 32'h0};
    vecs[7] = '{1'b0, 5'd4,  32'h7FFF_F800, 8'h00, 2, 32'h8000_0237, 32'h8002_0213};
    vecs[8] = '{1'b0, 5'd6,  32'h0000_0005, 8'h00, 1, 32'h0050_0313, 32'h0};

    iRST = 1'b1; iREQ_VALID = 1'b0; iMODE = 1'b0; iRD = '0; iVALUE = '0; iPC = '0;
    iIR_READY = 1'b0;
    @(negedge iCLK); @(negedge iCLK);
    chk("rst ready", {31'b0, oREQ_READY}, 32'd0);
    chk("rst valid", {31'b0, oIR_VALID}, 32'd0);
    chk("rst ir", oIR, 32'd0);
    chk("rst last", {31'b0, oLAST}, 32'd0);
    iRST = 1'b0;
    @(negedge iCLK);
    chk("post rst ready", {31'b0, oREQ_READY}, 32'd1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Backpressure with an ignored second request while busy.
    iIR_READY = 1'b0;
    request(1'b0, 5'd5, 32'h1234_5678, 8'h00);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp hold ir c%0d", c), oIR, 32'h1234_52B7);
      chk($sformatf("bp hold valid c%0d", c), {31'b0, oIR_VALID}, 32'd1);
      chk($sformatf("bp hold last c%0d", c), {31'b0, oLAST}, 32'd0);
      chk($sformatf("bp ready c%0d", c), {31'b0, oREQ_READY}, 32'd0);
      if (c == 1) begin
        iMODE = 1'b0; iRD = 5'd3; iVALUE = 32'hABCD_E000; iREQ_VALID = 1'b1;
      end else begin
        iREQ_VALID = 1'b0;
      end
      @(negedge iCLK);
    end
    iREQ_VALID = 1'b0;
    iIR_READY = 1'b1;
    @(negedge iCLK);
    chk("bp w2", oIR, 32'h6782_8293);
    chk("bp w2 last", {31'b0, oLAST}, 32'd1);
    @(negedge iCLK);
    chk("bp idle valid", {31'b0, oIR_VALID}, 32'd0);
    @(negedge iCLK);
    chk("bp not queued", {31'b0, oIR_VALID}, 32'd0);
    chk("bp ready", {31'b0, oREQ_READY}, 32'd1);

    // Reset while the ADDI is presented.
    mon_en = 1'b1;
    iIR_READY = 1'b1;
    request(1'b0, 5'd5, 32'h1234_5678, 8'h00);
    chk("rs w1", oIR, 32'h1234_52B7);
    @(negedge iCLK);
    chk("rs w2", oIR, 32'h6782_8293);
    iIR_READY = 1'b0;
    iRST = 1'b1;
    @(negedge iCLK);
    chk("rs valid", {31'b0, oIR_VALID}, 32'd0);
    chk("rs ir", oIR, 32'd0);
    chk("rs ready during", {31'b0, oREQ_READY}, 32'd0);
    iRST = 1'b0;
    iIR_READY = 1'b1;
    @(negedge iCLK);
    chk("rs ready after", {31'b0, oREQ_READY}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rs no emit c%0d", c), {31'b0, oIR_VALID}, 32'd0);
      @(negedge iCLK);
    end
    chk("rs addi handshakes", addi_hs, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
